// File: rtl/divider.sv
// Divides I_CLK by DIV_N into a registered square wave O_CLK.
// Optional DIVIDER_TICK_EN adds O_TICK, a one-cycle pulse coinciding with each O_CLK rise.
module divider #(
  parameter int DIV_N = 20,
  parameter int CNT_W = $clog2(DIV_N)
) (
  input  logic I_CLK,
  input  logic rst,
  output logic O_CLK
`ifdef DIVIDER_TICK_EN
  ,
  output logic O_TICK
`endif
);

  generate
    if (DIV_N < 2) begin : g_bad_ratio
      $error("divider: DIV_N must be at least 2");
    end
  endgenerate

  // Low phase is the shorter half, so odd ratios stretch the high phase by one cycle.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] LOW_LEN = CNT_W'(DIV_N / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    clk_d = (cnt_d >= LOW_LEN);
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign O_CLK = clk_q;

`ifdef DIVIDER_TICK_EN
  logic tick_q;

  always_ff @(posedge I_CLK) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= (cnt_d == LOW_LEN);
  end

  assign O_TICK = tick_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider at DIV_N = 20, 5 and 2, sharing one clock and reset.
// Expected outputs come from edge counting since the last reset edge.
module tb_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o20, o5, o2;
`ifdef DIVIDER_TICK_EN
  logic t20, t5, t2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider #(.DIV_N(20)) u_div20 (
    .I_CLK(clk), .rst(rst), .O_CLK(o20)
`ifdef DIVIDER_TICK_EN
    , .O_TICK(t20)
`endif
  );

  divider #(.DIV_N(5)) u_div5 (
    .I_CLK(clk), .rst(rst), .O_CLK(o5)
`ifdef DIVIDER_TICK_EN
    , .O_TICK(t5)
`endif
  );

  divider #(.DIV_N(2)) u_div2 (
    .I_CLK(clk), .rst(rst), .O_CLK(o2)
`ifdef DIVIDER_TICK_EN
    , .O_TICK(t2)
`endif
  );

  // k = number of non-reset edges since the last reset edge
  function automatic logic exp_clk(input int k, input int n);
    return ((k % n) >= (n / 2));
  endfunction

  function automatic logic exp_tick(input int k, input int n);
    return (k > 0) && ((k % n) == (n / 2));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({o20, o5, o2} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold edge %0d: got o20/o5/o2=%b%b%b want 000", i, o20, o5, o2);
      end
`ifdef DIVIDER_TICK_EN
      n_cmp++;
      if ({t20, t5, t2} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_tick edge %0d: got %b%b%b want 000", i, t20, t5, t2);
      end
`endif
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (o20 !== exp_clk(k, 20)) begin
        n_err++;
        $display("FAIL hold_release edge %0d: got %b want %b", k, o20, exp_clk(k, 20));
      end
    end
  endtask

  task automatic test_first_period();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step();
      n_cmp++;
      if (o20 !== exp_clk(k, 20)) begin
        n_err++;
        $display("FAIL period20 edge %0d: got %b want %b", k, o20, exp_clk(k, 20));
      end
`ifdef DIVIDER_TICK_EN
      n_cmp++;
      if (t20 !== exp_tick(k, 20)) begin
        n_err++;
        $display("FAIL tick20 edge %0d: got %b want %b", k, t20, exp_tick(k, 20));
      end
`endif
    end
  endtask

  // Follows test_first_period directly: O_CLK is high here (edge 35).
  task automatic test_mid_reset();
    n_cmp++;
    if (o20 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_pre: got %b want 1", o20);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (o20 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_edge: got %b want 0", o20);
    end
    rst = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      step();
      n_cmp++;
      if (o20 !== exp_clk(k, 20)) begin
        n_err++;
        $display("FAIL mid_reset_repeat edge %0d: got %b want %b", k, o20, exp_clk(k, 20));
      end
    end
  endtask

  task automatic test_div2();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (o2 !== logic'(k % 2)) begin
        n_err++;
        $display("FAIL div2 edge %0d: got %b want %b", k, o2, logic'(k % 2));
      end
    end
  endtask

  task automatic test_div5();
    logic [9:0] pat;
    pat = 10'b0111001110;  // edges 1..10, MSB first
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if (o5 !== pat[10 - k]) begin
        n_err++;
        $display("FAIL div5 edge %0d: got %b want %b", k, o5, pat[10 - k]);
      end
    end
  endtask

  task automatic test_random();
    int k;
    logic r;
    k = 0;
    rst = 1'b1;
    step();
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 24) == 0);
      rst = r;
      step();
      if (r) k = 0;
      else   k++;
      n_cmp++;
      if ({o20, o5, o2} !== {exp_clk(k, 20), exp_clk(k, 5), exp_clk(k, 2)}) begin
        n_err++;
        $display("FAIL random cycle %0d k=%0d: got %b%b%b want %b%b%b", i, k, o20, o5, o2,
                 exp_clk(k, 20), exp_clk(k, 5), exp_clk(k, 2));
      end
`ifdef DIVIDER_TICK_EN
      n_cmp++;
      if ({t20, t5, t2} !== {exp_tick(k, 20), exp_tick(k, 5), exp_tick(k, 2)}) begin
        n_err++;
        $display("FAIL random_tick cycle %0d k=%0d: got %b%b%b want %b%b%b", i, k, t20, t5, t2,
                 exp_tick(k, 20), exp_tick(k, 5), exp_tick(k, 2));
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_period();
    test_mid_reset();
    test_div2();
    test_div5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
